// File: rtl/qs_pkg.sv
// Shared quadrature-sequence definitions: {A,B} phase codes, direction encoding
// and the one-position stepper used by both the emitter and the detector.
package qs_pkg;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_10 = 2'b10;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_01 = 2'b01;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // The state encoding is the {A,B} pair itself, so the outputs come straight off the flops.
    typedef enum logic [1:0] {
        SEQ_0 = PH_00,
        SEQ_1 = PH_10,
        SEQ_2 = PH_11,
        SEQ_3 = PH_01
    } seq_state_t;

    function automatic seq_state_t next_phase(input seq_state_t cur, input logic up);
        seq_state_t nxt;
        case (cur)
            SEQ_0:   nxt = (up == DIR_UP) ? SEQ_1 : SEQ_3;
            SEQ_1:   nxt = (up == DIR_UP) ? SEQ_2 : SEQ_0;
            SEQ_2:   nxt = (up == DIR_UP) ? SEQ_3 : SEQ_1;
            SEQ_3:   nxt = (up == DIR_UP) ? SEQ_0 : SEQ_2;
            default: nxt = SEQ_0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/quad_phase_seq.sv
// Two-bit quadrature state stepper: advances one position up or down per adv pulse.
//
//  state | meaning
//  SEQ_0 | (A,B) = (0,0), reset state
//  SEQ_1 | (A,B) = (1,0)
//  SEQ_2 | (A,B) = (1,1)
//  SEQ_3 | (A,B) = (0,1)
module quad_phase_seq
    import qs_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic adv,
    input  logic up,
    output logic phaseA,
    output logic phaseB
);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [1:0] state_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEQ_0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (adv) begin
            state_d = next_phase(state_q, up);
        end
    end

    assign state_bits = state_q;
    assign phaseA     = state_bits[1];
    assign phaseB     = state_bits[0];

endmodule

// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: buffers step/dir commands in a saturating signed
// pending counter and replays them as A/B edges with a minimum edge spacing.
module quad_encoder_emulator
    import qs_pkg::*;
#(
    parameter int PENDING_BITS   = 16,
    parameter int MIN_EDGE_TICKS = 16,
    parameter int COUNT_BITS     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step,
    input  logic                  dir,
    input  logic                  clr_overflow,
    output logic                  phaseA,
    output logic                  phaseB,
    output logic [COUNT_BITS-1:0] position,
    output logic                  busy,
    output logic                  overflow
);

    localparam int TIMER_BITS = (MIN_EDGE_TICKS > 1) ? $clog2(MIN_EDGE_TICKS) : 1;
    localparam logic [TIMER_BITS-1:0] TIMER_LOAD = TIMER_BITS'(MIN_EDGE_TICKS - 1);

    localparam logic signed [PENDING_BITS:0] P_MAX = {2'b00, {(PENDING_BITS-1){1'b1}}};
    localparam logic signed [PENDING_BITS:0] P_MIN = {2'b11, {(PENDING_BITS-1){1'b0}}};
    localparam logic signed [PENDING_BITS:0] P_ONE = (PENDING_BITS+1)'(1);
    localparam logic [COUNT_BITS-1:0]        C_ONE = COUNT_BITS'(1);

    logic signed [PENDING_BITS-1:0] pending_q, pending_d;
    logic [TIMER_BITS-1:0]          timer_q, timer_d;
    logic [COUNT_BITS-1:0]          position_q, position_d;
    logic                           busy_q, busy_d;
    logic                           overflow_q, overflow_d;

    logic                           emit;
    logic                           emit_up;
    logic signed [PENDING_BITS:0]   pending_sum;
    logic                           saturate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= '0;
            timer_q    <= '0;
            position_q <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            position_q <= position_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    assign emit    = (timer_q == '0) && (pending_q != '0);
    assign emit_up = !pending_q[PENDING_BITS-1];

    always_comb begin
        pending_sum = {pending_q[PENDING_BITS-1], pending_q};
        if (step) begin
            pending_sum = (dir == DIR_UP) ? pending_sum + P_ONE : pending_sum - P_ONE;
        end
        if (emit) begin
            pending_sum = emit_up ? pending_sum - P_ONE : pending_sum + P_ONE;
        end
    end

    // The extra bit of pending_sum holds the out-of-range value; clamping drops the step.
    always_comb begin
        saturate  = 1'b0;
        pending_d = pending_sum[PENDING_BITS-1:0];
        if (pending_sum > P_MAX) begin
            saturate  = 1'b1;
            pending_d = P_MAX[PENDING_BITS-1:0];
        end else if (pending_sum < P_MIN) begin
            saturate  = 1'b1;
            pending_d = P_MIN[PENDING_BITS-1:0];
        end
    end

    always_comb begin
        timer_d    = timer_q;
        position_d = position_q;
        if (emit) begin
            timer_d    = TIMER_LOAD;
            position_d = emit_up ? position_q + C_ONE : position_q - C_ONE;
        end else if (timer_q != '0) begin
            timer_d = timer_q - TIMER_BITS'(1);
        end
    end

    // A saturation in the same cycle as a clear wins, so no dropped step goes unreported.
    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (saturate) begin
            overflow_d = 1'b1;
        end
    end

    assign busy_d = (pending_d != '0);

    quad_phase_seq u_phase_seq (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (emit),
        .up     (emit_up),
        .phaseA (phaseA),
        .phaseB (phaseB)
    );

    assign position = position_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule
